// File: rtl/modmul.sv
// Modular multiplier over GF(29): m = (a*b) mod 29 using MSB-first interleaved reduction.
// Define MODMUL_REG_EN to register m on clk with a synchronous active-high reset.
module modmul (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [4:0] m
);

   localparam logic [6:0] MODULUS    = 7'd29;
   localparam logic [6:0] MODULUS_X2 = 7'd58;

   logic [6:0] a_red;
   logic [6:0] r_acc;
   logic [6:0] t_stage;
   logic [4:0] m_comb;
   logic       unused_bits;

   // Each stage keeps r in 0..28, so 2*r + a' never exceeds 84 and fits in 7 bits.
   always_comb begin
      a_red   = ({2'b00, a} >= MODULUS) ? ({2'b00, a} - MODULUS) : {2'b00, a};
      r_acc   = '0;
      t_stage = '0;
      for (int i = 4; i >= 0; i--) begin
         t_stage = {r_acc[5:0], 1'b0} + (b[i] ? a_red : 7'd0);
         if (t_stage >= MODULUS_X2) t_stage = t_stage - MODULUS_X2;
         if (t_stage >= MODULUS)    t_stage = t_stage - MODULUS;
         r_acc = t_stage;
      end
      m_comb = r_acc[4:0];
   end

   // Upper bits of r are provably zero; clk/reset are idle in the combinational build.
   assign unused_bits = ^{clk, reset, r_acc[6:5]};

`ifdef MODMUL_REG_EN
   always_ff @(posedge clk) begin
      if (reset) m <= '0;
      else       m <= m_comb;
   end
`else
   assign m = m_comb;
`endif

endmodule

// File: tb/tb_modmul.sv
// Self-checking bench for modmul against a plain-arithmetic (a*b) mod 29 model.
// Covers both the combinational build and the MODMUL_REG_EN registered build.
module tb_modmul;

   logic       clk;
   logic       reset;
   logic [4:0] a;
   logic [4:0] b;
   logic [4:0] m;

   int n_checks = 0;
   int n_fail   = 0;

   modmul dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .m     (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] model(input int x, input int y);
      return 5'((x * y) % 29);
   endfunction

   // Drive one operand pair and wait until the result is observable.
   task automatic apply(input int x, input int y);
`ifdef MODMUL_REG_EN
      a = 5'(x);
      b = 5'(y);
      @(posedge clk);
      #1;
`else
      #5;
      a = 5'(x);
      b = 5'(y);
      #5;
`endif
   endtask

   task automatic test_reset;
`ifdef MODMUL_REG_EN
      reset = 1'b1;
      a = 5'd31;
      b = 5'd31;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (m !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_hold: m=%0d expected=0", m);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (m !== 5'd4) begin
         n_fail++;
         $display("FAIL reset_release: m=%0d expected=4", m);
      end
      a = 5'd5;
      b = 5'd6;
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_midstream: m=%0d expected=0", m);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (m !== 5'd1) begin
         n_fail++;
         $display("FAIL reset_first_result: m=%0d expected=1", m);
      end
`else
      // Reset has no effect in the combinational build.
      reset = 1'b1;
      apply(31, 31);
      n_checks++;
      if (m !== 5'd4) begin
         n_fail++;
         $display("FAIL reset_ignored: m=%0d expected=4", m);
      end
      reset = 1'b0;
      apply(17, 12);
      n_checks++;
      if (m !== 5'd1) begin
         n_fail++;
         $display("FAIL reset_released: m=%0d expected=1", m);
      end
`endif
   endtask

   task automatic test_corners;
      int ca[8] = '{31, 28, 30, 17, 5, 0, 29, 13};
      int cb[8] = '{31, 28, 30, 12, 6, 31, 17, 29};
      int ce[8] = '{4, 1, 1, 1, 1, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         apply(ca[i], cb[i]);
         n_checks++;
         if (m !== 5'(ce[i])) begin
            n_fail++;
            $display("FAIL corner a=%0d b=%0d: m=%0d expected=%0d", ca[i], cb[i], m, ce[i]);
         end
      end
   endtask

   task automatic test_exhaustive;
      int errs = 0;
      for (int x = 0; x < 32; x++) begin
         for (int y = 0; y < 32; y++) begin
            apply(x, y);
            n_checks++;
            if (m !== model(x, y)) begin
               n_fail++;
               errs++;
               if (errs <= 10)
                  $display("FAIL exhaustive a=%0d b=%0d: m=%0d expected=%0d", x, y, m, model(x, y));
            end
         end
      end
   endtask

   task automatic test_unreduced;
      for (int y = 0; y < 32; y++) begin
         apply(30, y);
         n_checks++;
         if (m !== model(1, y)) begin
            n_fail++;
            $display("FAIL unreduced_a30 b=%0d: m=%0d expected=%0d", y, m, model(1, y));
         end
         apply(31, y);
         n_checks++;
         if (m !== model(2, y)) begin
            n_fail++;
            $display("FAIL unreduced_a31 b=%0d: m=%0d expected=%0d", y, m, model(2, y));
         end
      end
   endtask

   task automatic test_random;
      int x;
      int y;
      for (int i = 0; i < 300; i++) begin
         x = int'($urandom_range(0, 31));
         y = int'($urandom_range(0, 31));
         apply(x, y);
         n_checks++;
         if (m !== model(x, y)) begin
            n_fail++;
            $display("FAIL random a=%0d b=%0d: m=%0d expected=%0d", x, y, m, model(x, y));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      a = '0;
      b = '0;
      #2;
      test_reset;
      reset = 1'b0;
      test_corners;
      test_exhaustive;
      test_unreduced;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modmul.md
Name: modmul

Overview:
- Modular multiplier over GF(29): m = (a * b) mod 29, with 5-bit operands and a 5-bit result.
- Used as a small arithmetic leaf in the ASIC optimisation flow.
- Default build is purely combinational; clk and reset are present for the optional output-register build.
- Operands may be unreduced (29..31); the block reduces them itself.

Parameters:
- none: width (5) and modulus (29) are fixed constants inside the block, not overridable.

Ports:
- clk  input  1  system clock. Only used when MODMUL_REG_EN is defined; otherwise left unconnected or ignored.
- reset  input  1  synchronous, active-high reset. Only used when MODMUL_REG_EN is defined; otherwise ignored.
- a  input  5  multiplicand, unsigned 0..31 (values 29..31 accepted unreduced).
- b  input  5  multiplier, unsigned 0..31 (values 29..31 accepted unreduced).
- m  output  5  result (a*b) mod 29, always in range 0..28.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Default build, combinational:
  - m depends only on a and b, with zero latency and no state.
  - m must settle within one stimulus period.
  - clk and reset have no effect.
  - Floating or undriven clk/reset must not corrupt m.
- Arithmetic: must equal (a*b) mod 29 for all 1024 input pairs. No use of the % or / operators.
- Datapath, interleaved MSB-first (Horner) reduction:
  - Operand pre-reduction: a' = a - 29 if a >= 29, else a (a' in 0..28).
  - r starts at 0.
  - For each bit of b, from b[4] down to b[0]: t = 2*r + (b[i] ? a' : 0).
  - t max is 2*28 + 28 = 84; t is 7 bits wide.
  - Reduce t to 0..28 by conditional subtraction: subtract 58 if t >= 58, then subtract 29 if the result is >= 29.
  - r = reduced t.
  - After 5 stages, m = r.
- Width rules:
  - Internal stage values use 7 bits; no overflow is possible.
  - m is the low 5 bits of the final r.
  - The upper bits of r are guaranteed 0.
- Boundary conditions:
  - a or b = 0 gives m = 0.
  - a or b = 29 gives m = 0.
  - a = 30 behaves as 1; a = 31 behaves as 2. The same holds for b, since b's bits are consumed unreduced but r is reduced every stage.
- No X-propagation on m for any known a/b. Purely combinational paths contain no latches.

Optional Feature:
- Macro: MODMUL_REG_EN.
- Defined:
  - m is driven by a 5-bit register updated on the rising edge of clk with the combinational result: latency 1 cycle, new value every cycle, no handshake.
  - reset high at a rising edge forces m = 0 (synchronous).
  - Asserting reset mid-stream drops the pending result. The first valid result appears one edge after reset deasserts, reflecting a/b sampled at that edge.
- Undefined:
  - Behaviour exactly as in the default combinational build.
  - No flops are inferred.

Test Plan:
- Exhaustive sweep: apply all 1024 (a,b) pairs, holding each for 10 time units, with clk/reset unconnected -> m == (a*b) mod 29 for every pair, no X.
- Corner products:
  - a=31, b=31 -> m=4.
  - a=28, b=28 -> m=1.
  - a=30, b=30 -> m=1.
  - a=17, b=12 -> m=1.
  - a=5, b=6 -> m=1.
- Zero and modulus operands:
  - a=0, b=31 -> m=0.
  - a=29, b=17 -> m=0.
  - a=13, b=29 -> m=0.
- Unreduced equivalence: for every b, a=30 gives the same m as a=1, and a=31 gives the same m as a=2.
- MODMUL_REG_EN build:
  - With reset=1 for 2 edges, then a=31, b=31 -> m=0 during reset.
  - After reset is released, m=4 one rising edge after a/b are sampled.
  - Asserting reset again -> m=0 at the next edge.
